instr_encode_loader: RTL and testbench

//  Encoder counterpart of the core's opcode decoder: accepts field-level instruction

---
 rtl/instr_encode_loader_pkg.sv | 21 ++
 rtl/instr_encode_loader_pack.sv | 42 ++++
 rtl/instr_encode_loader.sv | 127 ++++++++++++
 tb/tb_instr_encode_loader.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/instr_encode_loader_pkg.sv
// Shared definitions for the instruction encode/loader slice.
//  - RV32I opcode constants for the two supported formats
//  - the canonical NOP written in place of an unencodable command
//  - command kind encodings and the loader FSM state type
package instr_encode_loader_pkg;

  localparam logic [6:0]  OPC_RTYPE = 7'b0110011;
  localparam logic [6:0]  OPC_ITYPE = 7'b0010011;
  localparam logic [31:0] NOP_WORD  = 32'h00000013;  // addi x0, x0, 0

  localparam logic [1:0]  KIND_R    = 2'b00;
  localparam logic [1:0]  KIND_I    = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/instr_encode_loader_pack.sv
// Combinational field packer: turns a command kind plus fields into a 32-bit
// RV32I word.
//  kind           in  2   command kind (R, I, or illegal)
//  rd/rs1/rs2     in  5   register fields
//  funct3/funct7  in  3/7 function fields
//  imm            in  12  I-type immediate, placed verbatim in [31:20]
//  word           out 32  encoded instruction (NOP for illegal kinds)
//  illegal        out 1   kind was not encodable
module instr_pack
  import instr_encode_loader_pkg::*;
(
  input  logic [1:0]  kind,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [11:0] imm,
  output logic [31:0] word,
  output logic        illegal
);

  always_comb begin
    word    = NOP_WORD;
    illegal = 1'b1;
    case (kind)
      KIND_R: begin
        word    = {funct7, rs2, rs1, funct3, rd, OPC_RTYPE};
        illegal = 1'b0;
      end
      KIND_I: begin
        word    = {imm, rs1, funct3, rd, OPC_ITYPE};
        illegal = 1'b0;
      end
      default: begin
        word    = NOP_WORD;
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/instr_encode_loader.sv
// Program loader: accepts field-level instruction commands over valid/ready,
// encodes them and writes them to consecutive imem word addresses.
//  clk, rst         clock and synchronous active-high reset
//  start            begin a session (honoured only in IDLE or DONE)
//  cmd_*            command handshake and fields; cmd_last ends the session
//  imem_we/addr/wdata  registered imem write port, one cycle after accept
//  busy, done, err  session status; err is sticky until the next start
//  word_count       words written in the current session
module instr_encode_loader
  import instr_encode_loader_pkg::*;
#(
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int                DEPTH     = 256
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic [1:0]                  cmd_kind,
  input  logic [4:0]                  cmd_rd,
  input  logic [4:0]                  cmd_rs1,
  input  logic [4:0]                  cmd_rs2,
  input  logic [2:0]                  cmd_funct3,
  input  logic [6:0]                  cmd_funct7,
  input  logic [11:0]                 cmd_imm,
  input  logic                        cmd_last,
  output logic                        imem_we,
  output logic [ADDR_W-1:0]           imem_addr,
  output logic [31:0]                 imem_wdata,
  output logic                        busy,
  output logic                        done,
  output logic                        err,
  output logic [$clog2(DEPTH+1)-1:0]  word_count
);

  localparam int                CNT_W     = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(4);

  state_t              state_reg, state_next;
  logic                we_reg;
  logic [ADDR_W-1:0]   addr_out_reg;
  logic [ADDR_W-1:0]   addr_ptr_reg;   // address the next accepted word will use
  logic [31:0]         wdata_reg;
  logic [CNT_W-1:0]    count_reg;
  logic                err_reg;

  logic                accept;
  logic                restart;
  logic                last_slot;
  logic [31:0]         packed_word;
  logic                packed_illegal;

  instr_pack u_pack (
    .kind    (cmd_kind),
    .rd      (cmd_rd),
    .rs1     (cmd_rs1),
    .rs2     (cmd_rs2),
    .funct3  (cmd_funct3),
    .funct7  (cmd_funct7),
    .imm     (cmd_imm),
    .word    (packed_word),
    .illegal (packed_illegal)
  );

  // Ready depends only on registered state, so the host sees no comb path
  // from its own valid back into ready.
  assign cmd_ready = (state_reg == ST_LOAD) && (count_reg < DEPTH_C);
  assign accept    = cmd_valid && cmd_ready;
  assign restart   = start && ((state_reg == ST_IDLE) || (state_reg == ST_DONE));
  // The command being accepted occupies the final slot of the session.
  assign last_slot = ((count_reg + CNT_ONE) == DEPTH_C);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (start) state_next = ST_LOAD;
      ST_LOAD:  if (accept && (cmd_last || last_slot)) state_next = ST_FLUSH;
      ST_FLUSH: state_next = ST_DONE;   // the final write is on the port now
      ST_DONE:  if (start) state_next = ST_LOAD;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_reg <= ST_IDLE;
    else     state_reg <= state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      we_reg       <= 1'b0;
      addr_out_reg <= BASE_ADDR;
      addr_ptr_reg <= BASE_ADDR;
      wdata_reg    <= '0;
      count_reg    <= '0;
      err_reg      <= 1'b0;
    end else begin
      we_reg <= accept;
      if (restart) begin
        addr_out_reg <= BASE_ADDR;
        addr_ptr_reg <= BASE_ADDR;
        count_reg    <= '0;
        err_reg      <= 1'b0;
      end else if (accept) begin
        addr_out_reg <= addr_ptr_reg;
        addr_ptr_reg <= addr_ptr_reg + ADDR_STEP;  // wraps modulo 2^ADDR_W
        wdata_reg    <= packed_word;
        count_reg    <= count_reg + CNT_ONE;
        // Running out of slots before cmd_last counts as an overflow.
        if (packed_illegal || (last_slot && !cmd_last)) err_reg <= 1'b1;
      end
    end
  end

  assign imem_we    = we_reg;
  assign imem_addr  = addr_out_reg;
  assign imem_wdata = wdata_reg;
  assign busy       = (state_reg == ST_LOAD) || (state_reg == ST_FLUSH);
  assign done       = (state_reg == ST_DONE);
  assign err        = err_reg;
  assign word_count = count_reg;

endmodule

// File: tb/tb_instr_encode_loader.sv
// Directed self-checking bench for instr_encode_loader (DEPTH=4, BASE_ADDR=0).
module tb_instr_encode_loader;
  import instr_encode_loader_pkg::*;

  logic        clk = 1'b0;
  logic        rst, start, cmd_valid, cmd_ready, cmd_last;
  logic [1:0]  cmd_kind;
  logic [4:0]  cmd_rd, cmd_rs1, cmd_rs2;
  logic [2:0]  cmd_funct3;
  logic [6:0]  cmd_funct7;
  logic [11:0] cmd_imm;
  logic        imem_we, busy, done, err;
  logic [31:0] imem_addr, imem_wdata;
  logic [2:0]  word_count;

  int tests_run = 0;
  int fails     = 0;
  int wr_cnt    = 0;

  always #5 clk = ~clk;

  instr_encode_loader #(.ADDR_W(32), .BASE_ADDR(32'h0), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .start(start),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_kind(cmd_kind),
    .cmd_rd(cmd_rd), .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2),
    .cmd_funct3(cmd_funct3), .cmd_funct7(cmd_funct7), .cmd_imm(cmd_imm),
    .cmd_last(cmd_last), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .busy(busy), .done(done), .err(err),
    .word_count(word_count)
  );

  // Count write strobes mid-cycle, away from the active edge.
  always @(negedge clk) if (imem_we === 1'b1) wr_cnt++;

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
    $display("[TB] %s observed=0x%08h expected=0x%08h", tag, obs, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_start;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Present one command, wait (bounded) for acceptance, then check the write
  // that must appear in the cycle after the accepting edge. valid stays high.
  task automatic send(input string tag, input logic [1:0] k, input logic [4:0] rd,
                      input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                      input logic [6:0] f7, input logic [11:0] imm, input logic last,
                      input logic [31:0] exp_w, input logic [31:0] exp_a);
    int n;
    cmd_kind = k; cmd_rd = rd; cmd_rs1 = rs1; cmd_rs2 = rs2;
    cmd_funct3 = f3; cmd_funct7 = f7; cmd_imm = imm; cmd_last = last;
    cmd_valid = 1'b1;
    chk({tag, "_ready"}, 32'(cmd_ready), 32'd1);
    n = 0;
    while (cmd_ready !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    tick();
    chk({tag, "_we"},    32'(imem_we), 32'd1);
    chk({tag, "_addr"},  imem_addr,    exp_a);
    chk({tag, "_wdata"}, imem_wdata,   exp_w);
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (done !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  int base_wr;

  initial begin
    rst = 1'b1; start = 1'b1; cmd_valid = 1'b0; cmd_last = 1'b0;
    cmd_kind = 2'b00; cmd_rd = '0; cmd_rs1 = '0; cmd_rs2 = '0;
    cmd_funct3 = '0; cmd_funct7 = '0; cmd_imm = '0;
    tick(); tick();
    // reset (with start held: reset wins)
    chk("rst_busy",  32'(busy),       32'd0);
    chk("rst_ready", 32'(cmd_ready),  32'd0);
    chk("rst_we",    32'(imem_we),    32'd0);
    chk("rst_addr",  imem_addr,       32'h0);
    chk("rst_wdata", imem_wdata,      32'h0);
    chk("rst_done",  32'(done),       32'd0);
    chk("rst_err",   32'(err),        32'd0);
    chk("rst_wc",    32'(word_count), 32'd0);
    rst = 1'b0; start = 1'b0;
    tick();
    chk("idle_ready", 32'(cmd_ready), 32'd0);

    // 1: single R command
    base_wr = wr_cnt;
    do_start();
    chk("t1_busy", 32'(busy), 32'd1);
    send("t1", KIND_R, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 12'd0, 1'b1, 32'h002081B3, 32'h0);
    cmd_valid = 1'b0;
    wait_done("t1");
    chk("t1_wc",  32'(word_count), 32'd1);
    chk("t1_err", 32'(err),        32'd0);
    chk("t1_nwr", 32'(wr_cnt - base_wr), 32'd1);

    // 2: I command with all-ones immediate
    do_start();
    chk("t2_done_clr", 32'(done), 32'd0);
    send("t2", KIND_I, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 12'hFFF, 1'b1, 32'hFFF00293, 32'h0);
    cmd_valid = 1'b0;
    wait_done("t2");

    // 3a: four back-to-back commands, last on the DEPTH-th word (no overflow)
    base_wr = wr_cnt;
    do_start();
    send("t3a0", KIND_R, 5'd1,  5'd2,  5'd3,  3'd0, 7'h20, 12'd0,   1'b0, 32'h403100B3, 32'h0);
    send("t3a1", KIND_I, 5'd6,  5'd7,  5'd0,  3'd0, 7'd0,  12'h123, 1'b0, 32'h12338313, 32'h4);
    send("t3a2", KIND_R, 5'd10, 5'd11, 5'd12, 3'd7, 7'd0,  12'd0,   1'b0, 32'h00C5F533, 32'h8);
    send("t3a3", KIND_I, 5'd31, 5'd31, 5'd0,  3'd4, 7'd0,  12'h800, 1'b1, 32'h800FCF93, 32'hC);
    cmd_valid = 1'b0;
    wait_done("t3a");
    chk("t3a_err", 32'(err), 32'd0);
    chk("t3a_wc",  32'(word_count), 32'd4);
    chk("t3a_nwr", 32'(wr_cnt - base_wr), 32'd4);

    // 3b: same commands with random valid gaps
    base_wr = wr_cnt;
    do_start();
    send("t3b0", KIND_R, 5'd1,  5'd2,  5'd3,  3'd0, 7'h20, 12'd0,   1'b0, 32'h403100B3, 32'h0);
    cmd_valid = 1'b0; repeat ($urandom_range(0, 3)) tick();
    send("t3b1", KIND_I, 5'd6,  5'd7,  5'd0,  3'd0, 7'd0,  12'h123, 1'b0, 32'h12338313, 32'h4);
    cmd_valid = 1'b0; repeat ($urandom_range(0, 3)) tick();
    send("t3b2", KIND_R, 5'd10, 5'd11, 5'd12, 3'd7, 7'd0,  12'd0,   1'b0, 32'h00C5F533, 32'h8);
    cmd_valid = 1'b0; repeat ($urandom_range(0, 3)) tick();
    send("t3b3", KIND_I, 5'd31, 5'd31, 5'd0,  3'd4, 7'd0,  12'h800, 1'b1, 32'h800FCF93, 32'hC);
    cmd_valid = 1'b0;
    wait_done("t3b");
    chk("t3b_nwr", 32'(wr_cnt - base_wr), 32'd4);

    // 4: overflow -- 6 commands offered, no last
    base_wr = wr_cnt;
    do_start();
    send("t4_0", KIND_R, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 12'd0, 1'b0, 32'h000000B3, 32'h0);
    send("t4_1", KIND_R, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 12'd0, 1'b0, 32'h00000133, 32'h4);
    send("t4_2", KIND_R, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 12'd0, 1'b0, 32'h000001B3, 32'h8);
    send("t4_3", KIND_R, 5'd4, 5'd0, 5'd0, 3'd0, 7'd0, 12'd0, 1'b0, 32'h00000233, 32'hC);
    chk("t4_ready_full", 32'(cmd_ready), 32'd0);
    repeat (6) tick();   // commands 5 and 6 held valid, must stay back-pressured
    chk("t4_ready_hold", 32'(cmd_ready), 32'd0);
    cmd_valid = 1'b0;
    wait_done("t4");
    chk("t4_err", 32'(err), 32'd1);
    chk("t4_wc",  32'(word_count), 32'd4);
    chk("t4_nwr", 32'(wr_cnt - base_wr), 32'd4);

    // 5: illegal kind writes NOP, sets err, still advances address
    do_start();
    chk("t5_err_clr", 32'(err), 32'd0);
    send("t5_ill", 2'b11, 5'd9, 5'd9, 5'd9, 3'd5, 7'h7F, 12'h555, 1'b0, 32'h00000013, 32'h0);
    chk("t5_err_set", 32'(err), 32'd1);
    send("t5_r",  KIND_R, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 12'd0, 1'b1, 32'h002081B3, 32'h4);
    cmd_valid = 1'b0;
    wait_done("t5");
    chk("t5_err", 32'(err), 32'd1);
    chk("t5_wc",  32'(word_count), 32'd2);

    // 6: reset right after an accept aborts the session
    do_start();
    send("t6_a", KIND_I, 5'd1, 5'd1, 5'd0, 3'd0, 7'd0, 12'h001, 1'b0, 32'h00108093, 32'h0);
    send("t6_b", KIND_I, 5'd2, 5'd2, 5'd0, 3'd0, 7'd0, 12'h002, 1'b0, 32'h00210113, 32'h4);
    rst = 1'b1;          // valid still high: nothing may be accepted
    tick();
    chk("t6_we",    32'(imem_we),    32'd0);
    chk("t6_addr",  imem_addr,       32'h0);
    chk("t6_wdata", imem_wdata,      32'h0);
    chk("t6_busy",  32'(busy),       32'd0);
    chk("t6_ready", 32'(cmd_ready),  32'd0);
    chk("t6_wc",    32'(word_count), 32'd0);
    start = 1'b1;        // start together with reset: reset wins
    tick();
    chk("t6_busy2", 32'(busy), 32'd0);
    rst = 1'b0; start = 1'b0; cmd_valid = 1'b0;
    tick();
    do_start();
    send("t6_c", KIND_R, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 12'd0, 1'b1, 32'h002081B3, 32'h0);
    cmd_valid = 1'b0;
    wait_done("t6");
    chk("t6_wc_end", 32'(word_count), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
